// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage registers.
package pipe_pkg;

  localparam int OCC_W = 2;

  // State encoding doubles as the held-beat count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } stage_state_e;

  function automatic logic [OCC_W-1:0] occ_of(input stage_state_e s);
    logic [OCC_W-1:0] occ;
    occ = '0;
    case (s)
      EMPTY:   occ = 2'd0;
      FULL:    occ = 2'd1;
      SKID:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  // Count up on inc, hold at all-ones, clear wins over increment.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: valid/ready handshake with a 2-entry
// skid buffer, synchronous flush, bubble masking of the control field and
// a saturating stall-cycle counter.
//
//   state | meaning
//   ------+-----------------------------------------------
//   EMPTY | nothing held, valid_o=0, ready_o=1
//   FULL  | main register holds one beat, skid empty
//   SKID  | main and skid both hold beats, ready_o=0
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  input  logic              flush_i,
  input  logic              clr_cnt_i,
  output logic [OCC_W-1:0]  occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  stage_state_e state_q, state_d;

  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;

  logic in_acc;
  logic out_drn;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  // ready_o and valid_o come straight from the state flops so there is no
  // combinational path from ready_i back to ready_o.
  assign ready_o = (state_q != SKID);
  assign valid_o = (state_q != EMPTY);
  assign occ_o   = occ_of(state_q);

  assign in_acc  = valid_i & ready_o;
  assign out_drn = valid_o & ready_i;

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and register-load decode; flush overrides everything and
  // discards any beat accepted in the same cycle.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;

    case (state_q)
      EMPTY: begin
        if (in_acc) begin
          state_d      = FULL;
          load_main_in = 1'b1;
        end
      end
      FULL: begin
        if (in_acc && out_drn) begin
          load_main_in = 1'b1;
        end else if (in_acc) begin
          state_d   = SKID;
          load_skid = 1'b1;
        end else if (out_drn) begin
          state_d = EMPTY;
        end
      end
      SKID: begin
        if (out_drn) begin
          state_d        = FULL;
          load_main_skid = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    if (flush_i) begin
      state_d        = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // Main register: loads from the input or promotes the skid entry.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      main_data_q <= '0;
      main_ctrl_q <= '0;
    end else if (load_main_in) begin
      main_data_q <= data_i;
      main_ctrl_q <= ctrl_i;
    end else if (load_main_skid) begin
      main_data_q <= skid_data_q;
      main_ctrl_q <= skid_ctrl_q;
    end
  end

  // Skid register: captures the beat that arrives while the main is stalled.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else if (load_skid) begin
      skid_data_q <= data_i;
      skid_ctrl_q <= ctrl_i;
    end
  end

  assign data_o = main_data_q;
  // Bubbles never carry control bits such as RegWrite/MemWrite.
  assign ctrl_o = valid_o ? main_ctrl_q : {CTRL_W{1'b0}};

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (valid_o & ~ready_i & ~flush_i),
    .clr   (clr_cnt_i),
    .cnt   (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with a queue-based reference model.
module tb_pipe_stage_reg;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 2;
  localparam int CNT_W  = 3;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              valid_i;
  logic              ready_o;
  logic [DATA_W-1:0] data_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic              valid_o;
  logic              ready_i;
  logic [DATA_W-1:0] data_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic              flush_i;
  logic              clr_cnt_i;
  logic [1:0]        occ_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } beat_t;

  beat_t sb[$];
  int    exp_cnt;
  int    checks   = 0;
  int    failures = 0;

  pipe_stage_reg #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (data_i),
    .ctrl_i      (ctrl_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .ctrl_o      (ctrl_o),
    .flush_i     (flush_i),
    .clr_cnt_i   (clr_cnt_i),
    .occ_o       (occ_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model state held before the next edge.
  task automatic check_outputs();
    chk("valid_o", 64'(valid_o), 64'(sb.size() > 0));
    chk("ready_o", 64'(ready_o), 64'(sb.size() < 2));
    chk("occ_o", 64'(occ_o), 64'(sb.size()));
    chk("stall_cnt_o", 64'(stall_cnt_o), 64'(exp_cnt));
    if (sb.size() > 0) begin
      chk("data_o", data_o, sb[0].d);
      chk("ctrl_o", 64'(ctrl_o), 64'(sb[0].c));
    end else begin
      chk("ctrl_o_bubble", 64'(ctrl_o), 64'd0);
    end
  endtask

  // Check, advance the model by one edge, then step to #1 after that edge.
  task automatic cycle();
    bit    drain;
    bit    accept;
    bit    stall;
    beat_t b;
    check_outputs();
    drain  = (sb.size() > 0) && ready_i;
    accept = valid_i && (sb.size() < 2) && !flush_i;
    stall  = (sb.size() > 0) && !ready_i && !flush_i;
    if (drain) void'(sb.pop_front());
    if (accept) begin
      b.d = data_i;
      b.c = ctrl_i;
      sb.push_back(b);
    end
    if (flush_i) sb.delete();
    if (clr_cnt_i) exp_cnt = 0;
    else if (stall && exp_cnt < (2**CNT_W - 1)) exp_cnt++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_reset();
    sb.delete();
    exp_cnt = 0;
  endtask

  initial begin
    rst_i     = 1'b0;
    valid_i   = 1'b0;
    data_i    = '0;
    ctrl_i    = '0;
    ready_i   = 1'b0;
    flush_i   = 1'b0;
    clr_cnt_i = 1'b0;
    model_reset();

    // Reset held for three cycles, then idle.
    repeat (3) @(posedge clk_i);
    #1;
    check_outputs();
    chk("rst_data_o", data_o, 64'd0);
    rst_i = 1'b1;
    cycle();
    cycle();

    // Streaming 1..8 with ready_i high.
    ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      valid_i = 1'b1;
      data_i  = 64'(i);
      ctrl_i  = 2'b11;
      cycle();
      chk("stream_occ", 64'(occ_o), 64'd1);
    end
    valid_i = 1'b0;
    cycle();
    cycle();

    // Backpressure into the skid, extra beat refused, then in-order drain.
    ready_i = 1'b0;
    valid_i = 1'b1; data_i = 64'hA; ctrl_i = 2'b01;
    cycle();
    data_i = 64'hB; ctrl_i = 2'b10;
    cycle();
    chk("skid_ready_o", 64'(ready_o), 64'd0);
    data_i = 64'hD; ctrl_i = 2'b11;
    cycle();
    cycle();
    valid_i = 1'b0;
    ready_i = 1'b1;
    cycle();
    chk("drain_occ_1", 64'(occ_o), 64'd1);
    cycle();
    chk("drain_occ_0", 64'(occ_o), 64'd0);
    cycle();

    // Flush while SKID with a simultaneous incoming beat 0xC.
    clr_cnt_i = 1'b1;
    cycle();
    clr_cnt_i = 1'b0;
    ready_i = 1'b0;
    valid_i = 1'b1; data_i = 64'h11; ctrl_i = 2'b11;
    cycle();
    data_i = 64'h22;
    cycle();
    flush_i = 1'b1;
    data_i  = 64'hC;
    cycle();
    flush_i = 1'b0;
    valid_i = 1'b0;
    chk("flush_valid_o", 64'(valid_o), 64'd0);
    chk("flush_ctrl_o", 64'(ctrl_o), 64'd0);
    ready_i = 1'b1;
    cycle();
    cycle();

    // Counter saturation, then clear beating a live increment.
    ready_i = 1'b0;
    valid_i = 1'b1; data_i = 64'h77; ctrl_i = 2'b01;
    cycle();
    valid_i = 1'b0;
    repeat (10) cycle();
    chk("stall_sat", 64'(stall_cnt_o), 64'd7);
    clr_cnt_i = 1'b1;
    cycle();
    clr_cnt_i = 1'b0;
    chk("stall_clr", 64'(stall_cnt_o), 64'd0);
    cycle();

    // Drain, refill into SKID, then asynchronous reset mid-cycle.
    ready_i = 1'b1;
    cycle();
    ready_i = 1'b0;
    valid_i = 1'b1; data_i = 64'h31; ctrl_i = 2'b10;
    cycle();
    data_i = 64'h32;
    cycle();
    valid_i = 1'b0;
    chk("pre_rst_occ", 64'(occ_o), 64'd2);
    #2;
    rst_i = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("arst_data_o", data_o, 64'd0);
    #1;
    rst_i = 1'b1;
    ready_i = 1'b1;
    valid_i = 1'b1; data_i = 64'h55; ctrl_i = 2'b11;
    cycle();
    chk("post_rst_valid", 64'(valid_o), 64'd1);
    chk("post_rst_data", data_o, 64'h55);
    valid_i = 1'b0;
    cycle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
